param_lap_timer: RTL
====================

Name: param_lap_timer

Overview:
- Parametrised successor to the fixed 4-digit, 2781 ms wrap timer/display top.
- Generates its own millisecond tick from the system clock.
- Keeps a wrapping binary count and a parallel BCD count.
- Drives NUM_DIGITS seven-segment digits with run, stop, freeze (lap hold) and error-override modes; sits directly under the board top.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- TICK_HZ, 1000, count rate; CLK_HZ/TICK_HZ must be an integer ≥2.
- NUM_DIGITS, 4, displayed digits, 2..8.
- WRAP_MS, 2781, last count value before wrap to 0. Elaboration error if WRAP_MS ≥ 10**NUM_DIGITS.
- ERR_W, 2, error code width, 1..4.

Ports:
- iClk, in, 1, system clock.
- iRst, in, 1, asynchronous, active-low reset.
- iEnable, in, 1, run/display enable (level).
- iFreeze, in, 1, lap toggle; acts on its rising edge.
- iClear, in, 1, synchronous counter clear (level).
- iErrorCodes, in, ERR_W, nonzero value = error present.
- oHEX, out, 7*NUM_DIGITS, active-low segments; digit k at [7k+6:7k], bit0=a..bit6=g, digit 0 least significant.
- oTime_msec, out, CW=$clog2(WRAP_MS+1), live binary count.
- oWrap, out, 1, one-cycle pulse on wrap.
- oState, out, 2, current FSM state.

Behaviour:
- Reset (iRst=0, async): prescaler, count, BCD digits, snapshot=0; state=STOP; oHEX all 1s (blank); oWrap=0; iFreeze edge register=0.
- Prescaler: counts 0..CLK_HZ/TICK_HZ-1 continuously; tick = terminal count, one cycle.
- Count advances on tick only in RUN, FROZEN, ERROR; holds in STOP.
  - At value WRAP_MS, a tick loads 0 and pulses oWrap in the same cycle as the count update. The count never exceeds WRAP_MS.
- BCD chain updates in lockstep with the binary count (per-digit 9→0 carry). It is zeroed at wrap and on clear.
- iClear=1: count, BCD and snapshot go to 0 next edge; overrides a coincident tick; no oWrap; state unchanged.
- Freeze edge: fr_edge = iFreeze & ~iFreeze_q (registered).
- FSM, evaluated each cycle in priority order:
  - iEnable=0 → STOP from any state.
  - STOP & iEnable → RUN.
  - RUN/FROZEN & iErrorCodes≠0 → ERROR. Error beats freeze when simultaneous; the snapshot is discarded.
  - ERROR & iErrorCodes==0 → RUN.
  - RUN & fr_edge → FROZEN; snapshot loads the current BCD digits.
  - FROZEN & fr_edge → RUN.
  - State encoding: STOP=0, RUN=1, FROZEN=2, ERROR=3.
- Display is registered, one cycle after the state/count it reflects:
  - STOP: all digits blank.
  - RUN: live BCD digits.
  - FROZEN: snapshot digits; the count keeps running underneath.
  - ERROR: digit NUM_DIGITS-1 = 'E' (0000110), digit 0 = hex of iErrorCodes, others blank.
- Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.

Optional Feature:
- PARAM_LAP_TIMER_LZ_BLANK_EN.
  - Defined: leading zero digits blank in RUN and FROZEN; digit 0 is always lit, so a count of 7 shows "   7".
  - Undefined: all digits shown, e.g. "0007".
  - ERROR and STOP display are unaffected either way.

Decomposition:
- Package param_lap_timer_pkg holds:
  - state enum (STOP, RUN, FROZEN, ERROR);
  - SEG_BLANK, SEG_E and the 16-entry segment constant table;
  - function clog2-safe width helper.
- One sub-module, seg7_hex_decode: 4-bit value + blank flag → 7-bit active-low segments, combinational. Instantiated NUM_DIGITS times via generate.

Test Plan (CLK_HZ=8000, TICK_HZ=1000, i.e. divide-by-8, unless noted):
- Reset then iEnable=1 for 8*25 cycles → oTime_msec=25; oHEX digit0=0010010, digit1=0100100, digits 2–3=1000000; oState=1.
- WRAP_MS=2781, run to 2781, one more tick → oTime_msec=0, oWrap high exactly 1 cycle, digits all 1000000; never reads 2782.
- At count 100, pulse iFreeze → oState=2, oHEX holds "0100" while oTime_msec reaches 140. Second iFreeze pulse → oState=1, display shows live count.
- In RUN, iErrorCodes=2'b10 together with an iFreeze edge → oState=3, digit3=0000110, digit0=0100100, digits 1–2 blank. Clear the error → RUN with live count.
- iClear asserted on a tick cycle → next oTime_msec=0, no oWrap. iRst low mid-RUN → async: oHEX all 1s, oState=0 before the next clock edge.
- NUM_DIGITS=6, WRAP_MS=99999 with LZ_BLANK_EN defined → count 42 shows only digits 0–1 lit; without the macro, six digits with leading zeros.

Source files
------------

// File: rtl/param_lap_timer_pkg.sv
// param_lap_timer_pkg
//   Shared types and constants for the parametrised lap timer.
//   - lapStateT    : display/counting mode (encoding is visible on oState)
//   - SEG_BLANK    : all segments off (active-low)
//   - SEG_E        : letter 'E' used by the error display
//   - SEG_TABLE    : hex digit 0..F to active-low segments, bit0=a .. bit6=g
//   - safeClog2    : ceil(log2(value)) clamped to at least 1 bit
package param_lap_timer_pkg;

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2,
    ERROR  = 2'd3
  } lapStateT;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // B
    7'b1000110,  // C
    7'b0100001,  // D
    7'b0000110,  // E
    7'b0001110   // F
  };

  // A counter that only ever holds 0 or 1 still needs one bit, which
  // $clog2 alone would report as zero.
  function automatic int safeClog2(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode
//   Combinational hex-to-seven-segment decoder, active-low outputs.
//   Ports:
//     value : 4-bit digit value 0..F
//     blank : 1 forces every segment off regardless of value
//     seg   : segments, bit0=a .. bit6=g, 0 = lit
module seg7_hex_decode
  import param_lap_timer_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : SEG_TABLE[value];
  end

endmodule

// File: rtl/param_lap_timer.sv
// param_lap_timer
//   Millisecond lap timer driving NUM_DIGITS seven-segment digits.
//   A free-running prescaler produces one tick every CLK_HZ/TICK_HZ clocks.
//   The count wraps from WRAP_MS to 0 and is mirrored by a BCD chain that
//   feeds the display. Modes: STOP (blank), RUN (live), FROZEN (lap
//   snapshot shown while counting continues), ERROR ('E' plus error code).
//
//   Optional build macro PARAM_LAP_TIMER_LZ_BLANK_EN: when defined, leading
//   zero digits are blanked in RUN and FROZEN (digit 0 always lit).
//
//   Ports:
//     iClk        : system clock
//     iRst        : asynchronous active-low reset
//     iEnable     : run/display enable, level
//     iFreeze     : lap toggle, acts on its rising edge
//     iClear      : synchronous clear of count, BCD and snapshot
//     iErrorCodes : nonzero means an error is present
//     oHEX        : active-low segments, digit k at [7k+6:7k]
//     oTime_msec  : live binary count
//     oWrap       : one-cycle pulse coincident with the count wrapping to 0
//     oState      : current mode (STOP=0, RUN=1, FROZEN=2, ERROR=3)
module param_lap_timer
  import param_lap_timer_pkg::*;
#(
  parameter  int CLK_HZ     = 50000000,
  parameter  int TICK_HZ    = 1000,
  parameter  int NUM_DIGITS = 4,
  parameter  int WRAP_MS    = 2781,
  parameter  int ERR_W      = 2,
  localparam int CW         = safeClog2(WRAP_MS + 1)
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iEnable,
  input  logic                    iFreeze,
  input  logic                    iClear,
  input  logic [ERR_W-1:0]        iErrorCodes,
  output logic [7*NUM_DIGITS-1:0] oHEX,
  output logic [CW-1:0]           oTime_msec,
  output logic                    oWrap,
  output logic [1:0]              oState
);

  localparam int     DIV         = CLK_HZ / TICK_HZ;
  localparam int     PW          = safeClog2(DIV);
  localparam longint DIGIT_LIMIT = longint'(10) ** NUM_DIGITS;

  generate
    if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : gBadDivider
      $error("param_lap_timer: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : gBadDigits
      $error("param_lap_timer: NUM_DIGITS must be 2..8");
    end
    if (ERR_W < 1 || ERR_W > 4) begin : gBadErrWidth
      $error("param_lap_timer: ERR_W must be 1..4");
    end
    if (longint'(WRAP_MS) >= DIGIT_LIMIT) begin : gBadWrap
      $error("param_lap_timer: WRAP_MS does not fit in NUM_DIGITS digits");
    end
  endgenerate

  logic [PW-1:0]           prescQ;
  logic                    tick;
  lapStateT                stateQ;
  lapStateT                stateD;
  logic                    loadSnap;
  logic                    errPresent;
  logic                    freezeQ;
  logic                    freezeEdge;
  logic [CW-1:0]           countQ;
  logic                    wrapQ;
  logic                    counting;
  logic                    atWrap;
  logic [4*NUM_DIGITS-1:0] bcdQ;
  logic [4*NUM_DIGITS-1:0] bcdInc;
  logic [4*NUM_DIGITS-1:0] snapQ;
  logic                    carry;
  logic [4*NUM_DIGITS-1:0] digVal;
  logic [NUM_DIGITS-1:0]   digBlank;
  logic [7*NUM_DIGITS-1:0] segP0;
  logic [7*NUM_DIGITS-1:0] segP1;
`ifdef PARAM_LAP_TIMER_LZ_BLANK_EN
  logic                    leadZero;
`endif

  // Prescaler: free-running in every mode so tick phase never depends on
  // when the timer was started.
  assign tick = (prescQ == PW'(DIV - 1));

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      prescQ <= '0;
    end else if (tick) begin
      prescQ <= '0;
    end else begin
      prescQ <= prescQ + PW'(1);
    end
  end

  // Freeze edge detect
  assign freezeEdge = iFreeze & ~freezeQ;
  assign errPresent = |iErrorCodes;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      freezeQ <= 1'b0;
    end else begin
      freezeQ <= iFreeze;
    end
  end

  // Mode FSM
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      stateQ <= STOP;
    end else begin
      stateQ <= stateD;
    end
  end

  // Error is tested before freeze, so a coincident freeze edge never loads
  // a snapshot on the way into ERROR.
  always_comb begin
    stateD   = stateQ;
    loadSnap = 1'b0;
    if (!iEnable) begin
      stateD = STOP;
    end else begin
      case (stateQ)
        STOP:    stateD = RUN;
        RUN: begin
          if (errPresent) begin
            stateD = ERROR;
          end else if (freezeEdge) begin
            stateD   = FROZEN;
            loadSnap = 1'b1;
          end
        end
        FROZEN: begin
          if (errPresent) begin
            stateD = ERROR;
          end else if (freezeEdge) begin
            stateD = RUN;
          end
        end
        ERROR: begin
          if (!errPresent) begin
            stateD = RUN;
          end
        end
        default: stateD = STOP;
      endcase
    end
  end

  // Binary and BCD counters
  assign counting = tick && (stateQ != STOP);
  assign atWrap   = (countQ == CW'(WRAP_MS));

  // Ripple a +1 through the BCD digits, each 9 rolling to 0 with carry.
  always_comb begin
    bcdInc = bcdQ;
    carry  = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (carry) begin
        if (bcdQ[4*k +: 4] == 4'd9) begin
          bcdInc[4*k +: 4] = 4'd0;
        end else begin
          bcdInc[4*k +: 4] = bcdQ[4*k +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      countQ <= '0;
      bcdQ   <= '0;
      snapQ  <= '0;
      wrapQ  <= 1'b0;
    end else begin
      wrapQ <= 1'b0;
      if (iClear) begin
        countQ <= '0;
        bcdQ   <= '0;
        snapQ  <= '0;
      end else begin
        if (counting) begin
          if (atWrap) begin
            countQ <= '0;
            bcdQ   <= '0;
            wrapQ  <= 1'b1;
          end else begin
            countQ <= countQ + CW'(1);
            bcdQ   <= bcdInc;
          end
        end
        if (loadSnap) begin
          snapQ <= bcdQ;
        end
      end
    end
  end

  // Display source select (stage p0)
  always_comb begin
    digVal   = '0;
    digBlank = '1;
`ifdef PARAM_LAP_TIMER_LZ_BLANK_EN
    leadZero = 1'b1;
`endif
    case (stateQ)
      RUN, FROZEN: begin
        digVal   = (stateQ == FROZEN) ? snapQ : bcdQ;
        digBlank = '0;
`ifdef PARAM_LAP_TIMER_LZ_BLANK_EN
        // Scan from the most significant digit down; blank until the first
        // nonzero digit. Digit 0 is never blanked.
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
          if (digVal[4*k +: 4] != 4'd0) begin
            leadZero = 1'b0;
          end
          digBlank[k] = leadZero;
        end
`endif
      end
      ERROR: begin
        digVal[4*(NUM_DIGITS-1) +: 4] = 4'hE;
        digBlank[NUM_DIGITS-1]        = 1'b0;
        digVal[3:0]                   = 4'(iErrorCodes);
        digBlank[0]                   = 1'b0;
      end
      default: begin
        digVal   = '0;
        digBlank = '1;
      end
    endcase
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : gDigit
    seg7_hex_decode uDecode (
      .value (digVal[4*k +: 4]),
      .blank (digBlank[k]),
      .seg   (segP0[7*k +: 7])
    );
  end

  // Display register (stage p1)
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      segP1 <= '1;
    end else begin
      segP1 <= segP0;
    end
  end

  assign oHEX       = segP1;
  assign oTime_msec = countQ;
  assign oWrap      = wrapQ;
  assign oState     = stateQ;

endmodule
